// File: rtl/sipo_pkg.sv
// Shared definitions for the serial-in/parallel-out deframer.
// Optional feature macro: PARITY_CHECK_EN (adds a trailing even-parity bit per frame).
package sipo_pkg;

    localparam int SIPO_DATA_W_DEFAULT = 8;

`ifdef PARITY_CHECK_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } sipo_state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1
    } sipo_state_e;
`endif

endpackage

// File: rtl/sipo_shift_core.sv
// Shift register and bit counter for the deframer; handles bit ordering.
// Optional feature macro: PARITY_CHECK_EN (word output becomes the settled register).
// DATA_W must be at least 2.
module sipo_shift_core
    import sipo_pkg::*;
#(
    parameter int DATA_W    = SIPO_DATA_W_DEFAULT,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sample,
    input  logic              serial_in,
    output logic [DATA_W-1:0] word,
    output logic              last_bit
);

    localparam int CNT_W = $clog2(DATA_W);

    logic [CNT_W-1:0]  count_r;
    logic [DATA_W-1:0] shift_r;
    logic [DATA_W-1:0] shift_next_s;

    // Insert the incoming bit at the end that matches the configured bit order
    always_comb begin
        shift_next_s = shift_r;
        if (MSB_FIRST) begin
            shift_next_s = {shift_r[DATA_W-2:0], serial_in};
        end else begin
            shift_next_s = {serial_in, shift_r[DATA_W-1:1]};
        end
    end

    assign last_bit = (count_r == CNT_W'(DATA_W - 1));

`ifdef PARITY_CHECK_EN
    // The word is complete in the register by the time the parity bit arrives
    assign word = shift_r;
`else
    // Without parity the frame completes on the last data edge, so expose the
    // word including the bit being sampled right now
    assign word = shift_next_s;
`endif

    // Sample one bit per enabled edge; counter wraps at the end of the data bits
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= {CNT_W{1'b0}};
            shift_r <= {DATA_W{1'b0}};
        end else if (sample) begin
            shift_r <= shift_next_s;
            if (last_bit) begin
                count_r <= {CNT_W{1'b0}};
            end else begin
                count_r <= count_r + CNT_W'(1);
            end
        end else begin
            count_r <= count_r;
            shift_r <= shift_r;
        end
    end

endmodule

// File: rtl/sipo_deframer.sv
// Serial-in/parallel-out deframer with a one-word holding register,
// valid/ready handshake and a sticky overrun flag.
// Optional feature macro: PARITY_CHECK_EN (even-parity bit after the data bits,
// reported on parity_err).
module sipo_deframer
    import sipo_pkg::*;
#(
    parameter int DATA_W    = SIPO_DATA_W_DEFAULT,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              serial_in,
    input  logic              shift_en,
    input  logic              out_ready,
    output logic [DATA_W-1:0] parallel_out,
    output logic              out_valid,
    output logic              overrun,
    output logic              busy
`ifdef PARITY_CHECK_EN
    ,
    output logic              parity_err
`endif
);

    sipo_state_e       state_r;
    sipo_state_e       state_next_s;
    logic              sample_s;
    logic              complete_s;
    logic              last_bit_s;
    logic [DATA_W-1:0] word_s;

`ifdef PARITY_CHECK_EN
    // 1 when data plus parity bit has odd weight, i.e. even parity violated
    function automatic logic parity_bad(input logic [DATA_W-1:0] data, input logic par);
        return ^{data, par};
    endfunction
`endif

    sipo_shift_core #(
        .DATA_W    (DATA_W),
        .MSB_FIRST (MSB_FIRST)
    ) u_core (
        .clk       (clk),
        .reset     (reset),
        .sample    (sample_s),
        .serial_in (serial_in),
        .word      (word_s),
        .last_bit  (last_bit_s)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: decide when to sample a data bit and when a frame completes
    always_comb begin
        state_next_s = state_r;
        sample_s     = 1'b0;
        complete_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (shift_en) begin
                    sample_s     = 1'b1;
                    state_next_s = ST_SHIFT;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (shift_en) begin
                    sample_s = 1'b1;
                    if (last_bit_s) begin
`ifdef PARITY_CHECK_EN
                        state_next_s = ST_PARITY;
`else
                        complete_s   = 1'b1;
                        state_next_s = ST_IDLE;
`endif
                    end else begin
                        state_next_s = ST_SHIFT;
                    end
                end else begin
                    state_next_s = ST_SHIFT;
                end
            end
`ifdef PARITY_CHECK_EN
            ST_PARITY: begin
                if (shift_en) begin
                    complete_s   = 1'b1;
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_PARITY;
                end
            end
`endif
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Holding register, handshake, sticky overrun and registered busy flag
    always_ff @(posedge clk) begin
        if (reset) begin
            parallel_out <= {DATA_W{1'b0}};
            out_valid    <= 1'b0;
            overrun      <= 1'b0;
            busy         <= 1'b0;
`ifdef PARITY_CHECK_EN
            parity_err   <= 1'b0;
`endif
        end else begin
            busy <= (state_next_s != ST_IDLE);
            if (complete_s) begin
                if (!out_valid || out_ready) begin
                    parallel_out <= word_s;
                    out_valid    <= 1'b1;
`ifdef PARITY_CHECK_EN
                    parity_err   <= parity_bad(word_s, serial_in);
`endif
                end else begin
                    overrun <= 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end else begin
                out_valid <= out_valid;
            end
        end
    end

endmodule

// File: tb/tb_sipo_deframer.sv
// Self-checking bench for sipo_deframer: directed scenarios plus a randomized
// run compared against a queue-based frame model.
module tb_sipo_deframer;

    localparam int W = 8;
`ifdef PARITY_CHECK_EN
    localparam int FL = W + 1;
`else
    localparam int FL = W;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         serial_in;
    logic         shift_en;
    logic         out_ready;
    logic [W-1:0] parallel_out;
    logic         out_valid;
    logic         overrun;
    logic         busy;
`ifdef PARITY_CHECK_EN
    logic         parity_err;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic         m_bits[$];
    logic [W-1:0] m_word;
    logic         m_valid;
    logic         m_overrun;
    logic         m_perr;

    always #5 clk = ~clk;

    sipo_deframer #(.DATA_W(W), .MSB_FIRST(1'b1)) dut (
        .clk          (clk),
        .reset        (reset),
        .serial_in    (serial_in),
        .shift_en     (shift_en),
        .out_ready    (out_ready),
        .parallel_out (parallel_out),
        .out_valid    (out_valid),
        .overrun      (overrun),
        .busy         (busy)
`ifdef PARITY_CHECK_EN
        ,
        .parity_err   (parity_err)
`endif
    );

    // Bit i of a transmitted frame: data MSB first, then even parity if enabled
    function automatic logic frame_bit(input logic [W-1:0] w, input int i);
        if (i < W) return w[W-1-i];
        return ^w;
    endfunction

    // Frame-level model: collect bits, build word when the frame is full
    task automatic model_update(input logic se, input logic b, input logic rdy, input logic rst);
        logic         done;
        logic [W-1:0] w;
        logic         par;
        done = 1'b0;
        w    = '0;
        par  = 1'b0;
        if (rst) begin
            m_bits.delete();
            m_word = '0; m_valid = 1'b0; m_overrun = 1'b0; m_perr = 1'b0;
            return;
        end
        if (se) begin
            m_bits.push_back(b);
            if (m_bits.size() == FL) begin
                done = 1'b1;
                for (int i = 0; i < W; i++) w[W-1-i] = m_bits[i];
                for (int i = 0; i < FL; i++) par = par ^ m_bits[i];
                m_bits.delete();
            end
        end
        if (done) begin
            if (!m_valid || rdy) begin
                m_word = w; m_valid = 1'b1; m_perr = par;
            end else begin
                m_overrun = 1'b1;
            end
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
    endtask

    // Drive one clock of inputs; outputs are stable #1 after the edge on return
    task automatic step(input logic se, input logic b, input logic rdy, input logic rst);
        shift_en = se; serial_in = b; out_ready = rdy; reset = rst;
        @(posedge clk);
        model_update(se, b, rdy, rst);
        #1;
    endtask

    task automatic send_frame(input logic [W-1:0] w, input logic rdy_last);
        for (int i = 0; i < FL; i++) step(1'b1, frame_bit(w, i), (i == FL-1) ? rdy_last : 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        step(1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if ({parallel_out, out_valid, overrun, busy} !== {8'h00, 1'b0, 1'b0, 1'b0})
            $display("FAIL reset_state got po=%h v=%b ov=%b b=%b exp po=00 v=0 ov=0 b=0",
                     parallel_out, out_valid, overrun, busy);
        else n_pass++;
    endtask

    task automatic test_basic();
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < FL - 1; i++) step(1'b1, frame_bit(8'hAA, i), 1'b0, 1'b0);
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b1)
            $display("FAIL basic_early got v=%b b=%b exp v=0 b=1", out_valid, busy);
        else n_pass++;
        step(1'b1, frame_bit(8'hAA, FL-1), 1'b0, 1'b0);
        n_checks++;
        if ({parallel_out, out_valid, overrun, busy} !== {8'hAA, 1'b1, 1'b0, 1'b0})
            $display("FAIL basic_word got po=%h v=%b ov=%b b=%b exp po=aa v=1 ov=0 b=0",
                     parallel_out, out_valid, overrun, busy);
        else n_pass++;
    endtask

    task automatic test_gap();
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, frame_bit(8'hAA, i), 1'b0, 1'b0);
        for (int g = 0; g < 3; g++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0);
            n_checks++;
            if (busy !== 1'b1 || out_valid !== 1'b0)
                $display("FAIL gap_busy cyc %0d got b=%b v=%b exp b=1 v=0", g, busy, out_valid);
            else n_pass++;
        end
        for (int i = 4; i < FL; i++) step(1'b1, frame_bit(8'hAA, i), 1'b0, 1'b0);
        n_checks++;
        if ({parallel_out, out_valid} !== {8'hAA, 1'b1})
            $display("FAIL gap_word got po=%h v=%b exp po=aa v=1", parallel_out, out_valid);
        else n_pass++;
    endtask

    task automatic test_overrun();
        step(1'b0, 1'b0, 1'b0, 1'b1);
        send_frame(8'hAA, 1'b0);
        send_frame(8'h55, 1'b0);
        n_checks++;
        if ({parallel_out, out_valid, overrun} !== {8'hAA, 1'b1, 1'b1})
            $display("FAIL overrun_hold got po=%h v=%b ov=%b exp po=aa v=1 ov=1",
                     parallel_out, out_valid, overrun);
        else n_pass++;
        step(1'b0, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if ({out_valid, overrun} !== {1'b0, 1'b1})
            $display("FAIL overrun_consume got v=%b ov=%b exp v=0 ov=1", out_valid, overrun);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        step(1'b0, 1'b0, 1'b0, 1'b1);
        send_frame(8'hAA, 1'b0);
        for (int i = 0; i < FL; i++) begin
            step(1'b1, frame_bit(8'h0F, i), (i == FL-1) ? 1'b1 : 1'b0, 1'b0);
            n_checks++;
            if (out_valid !== 1'b1)
                $display("FAIL b2b_valid bit %0d got v=%b exp v=1", i, out_valid);
            else n_pass++;
        end
        n_checks++;
        if ({parallel_out, overrun} !== {8'h0F, 1'b0})
            $display("FAIL b2b_word got po=%h ov=%b exp po=0f ov=0", parallel_out, overrun);
        else n_pass++;
    endtask

    task automatic test_abort();
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        n_checks++;
        if ({busy, out_valid} !== {1'b0, 1'b0})
            $display("FAIL abort_reset got b=%b v=%b exp b=0 v=0", busy, out_valid);
        else n_pass++;
        send_frame(8'hC3, 1'b0);
        n_checks++;
        if ({parallel_out, out_valid, overrun} !== {8'hC3, 1'b1, 1'b0})
            $display("FAIL abort_word got po=%h v=%b ov=%b exp po=c3 v=1 ov=0",
                     parallel_out, out_valid, overrun);
        else n_pass++;
    endtask

`ifdef PARITY_CHECK_EN
    task automatic test_parity();
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < W; i++) step(1'b1, frame_bit(8'hAA, i), 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if ({parallel_out, parity_err} !== {8'hAA, 1'b1})
            $display("FAIL parity_bad got po=%h pe=%b exp po=aa pe=1", parallel_out, parity_err);
        else n_pass++;
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < W; i++) step(1'b1, frame_bit(8'hAA, i), 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if ({parallel_out, parity_err} !== {8'hAA, 1'b0})
            $display("FAIL parity_good got po=%h pe=%b exp po=aa pe=0", parallel_out, parity_err);
        else n_pass++;
    endtask
`endif

    task automatic test_random();
        logic m_busy;
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int c = 0; c < 400; c++) begin
            step(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 79) == 0));
            m_busy = (m_bits.size() != 0);
            n_checks++;
            if ({parallel_out, out_valid, overrun, busy} !== {m_word, m_valid, m_overrun, m_busy})
                $display("FAIL random cyc %0d got po=%h v=%b ov=%b b=%b exp po=%h v=%b ov=%b b=%b",
                         c, parallel_out, out_valid, overrun, busy, m_word, m_valid, m_overrun, m_busy);
            else n_pass++;
`ifdef PARITY_CHECK_EN
            n_checks++;
            if (m_valid && parity_err !== m_perr)
                $display("FAIL random_parity cyc %0d got pe=%b exp pe=%b", c, parity_err, m_perr);
            else n_pass++;
`endif
        end
    endtask

    initial begin
        reset = 1'b1; shift_en = 1'b0; serial_in = 1'b0; out_ready = 1'b0;
        m_word = '0; m_valid = 1'b0; m_overrun = 1'b0; m_perr = 1'b0;
        test_reset();
        test_basic();
        test_gap();
        test_overrun();
        test_back_to_back();
        test_abort();
`ifdef PARITY_CHECK_EN
        test_parity();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sipo_deframer.md
SIPO_DEFRAMER -- requirements
Module: sipo_deframer

Interface
REQ-001 Parameter DATA_W, default 8, is the number of data bits per frame.
REQ-002 Parameter MSB_FIRST, default 1: 1 means the first sampled bit lands in bit DATA_W-1; 0 means it lands in bit 0.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port serial_in, input, 1 bit: serial data stream, fed directly from the upstream PISO serial_out.
REQ-006 Port shift_en, input, 1 bit: when high, serial_in SHALL be sampled at this edge.
REQ-007 Port out_ready, input, 1 bit: downstream accepts the held word.
REQ-008 Port parallel_out, output, DATA_W bits: the held, assembled word.
REQ-009 Port out_valid, output, 1 bit: parallel_out holds an unconsumed word.
REQ-010 Port overrun, output, 1 bit: sticky flag; a completed frame was dropped.
REQ-011 Port busy, output, 1 bit: a partial frame is in progress (state is not IDLE).

Function
REQ-012 The state machine SHALL have states IDLE, SHIFT and, only when PARITY_CHECK_EN is defined, PARITY.
REQ-013 From IDLE, an edge with shift_en=1 SHALL sample bit 1 and move to SHIFT; an edge with shift_en=0 SHALL leave the state unchanged.
REQ-014 In SHIFT, each shift_en=1 edge SHALL sample one bit and increment the bit counter; a shift_en=0 edge SHALL hold all state, so gaps are allowed.
REQ-015 The edge that samples bit DATA_W SHALL complete the frame and return the state to IDLE, or move it to PARITY when PARITY_CHECK_EN is defined.
REQ-016 On frame completion with out_valid=0, or with out_valid=1 and out_ready=1, the assembled word SHALL load into parallel_out and out_valid SHALL read 1 from the next cycle.
REQ-017 Latency SHALL be exactly one cycle from the final sampling edge to out_valid=1.
REQ-018 Handshake: out_valid=1 and out_ready=1 at an edge SHALL consume the word, and out_valid SHALL fall at that edge unless a new word loads at the same edge.
REQ-019 On simultaneous completion and consume, the new word SHALL replace the old one and out_valid SHALL stay 1 with no bubble.
REQ-020 On completion with out_valid=1 and out_ready=0, the new word SHALL be discarded, parallel_out SHALL be unchanged, and overrun SHALL set and stay set until reset.
REQ-021 parallel_out SHALL be stable while out_valid=1 and not consumed.
REQ-022 The bit counter SHALL wrap to 0 on frame completion, and the next frame SHALL start cleanly on the following shift_en edge.

Reset
REQ-023 reset=1 at an edge SHALL force state=IDLE, bit counter=0, shift register=0, parallel_out=0, out_valid=0, overrun=0, busy=0 (and parity_err=0 when PARITY_CHECK_EN is defined).
REQ-024 reset SHALL take priority over shift_en and out_ready; a mid-frame reset SHALL discard the partial frame, and a held word SHALL be lost.

Configuration
REQ-025 Macro PARITY_CHECK_EN, when defined, SHALL extend each frame by one even-parity bit sampled in state PARITY after the DATA_W data bits.
REQ-026 With PARITY_CHECK_EN defined, frame completion SHALL occur on the parity-bit edge.
REQ-027 With PARITY_CHECK_EN defined, output parity_err (1 bit) SHALL load together with parallel_out and SHALL be 1 when the XOR of data bits and parity bit is 1.
REQ-028 Without PARITY_CHECK_EN, the PARITY state and the parity_err port SHALL not exist, and frames SHALL be exactly DATA_W bits.

Structure
REQ-029 Shared package sipo_pkg SHALL hold the state encoding type and constant SIPO_DATA_W_DEFAULT=8.
REQ-030 Sub-module sipo_shift_core SHALL own the shift register and the bit counter, with MSB_FIRST handling; sipo_deframer SHALL own the FSM, the holding register and the flags.

Verification
REQ-031 Scenario: reset, then 8 consecutive shift_en=1 edges with serial bits 1,0,1,0,1,0,1,0, out_ready=0 -> parallel_out=8'hAA and out_valid=1 exactly one cycle after the 8th edge; overrun=0.
REQ-032 Scenario: same bits with shift_en deasserted for 3 cycles after bit 4 -> result still 8'hAA, and busy=1 throughout the gap.
REQ-033 Scenario: 8'hAA held with out_ready=0, then a second frame 8'h55 is sent -> parallel_out stays 8'hAA and overrun=1; raising out_ready then drops out_valid next cycle.
REQ-034 Scenario: out_ready=1 at the exact edge the second frame (8'h0F) completes -> parallel_out=8'h0F and out_valid stays 1 continuously.
REQ-035 Scenario: reset asserted after bit 5 of a frame, then a full frame 8'hC3 is sent -> parallel_out=8'hC3 with no residue from the aborted bits.
REQ-036 Scenario: with PARITY_CHECK_EN defined, send 8'hAA then parity bit 1 -> parity_err=1; send 8'hAA then parity bit 0 -> parity_err=0.
